// File: rtl/brick_pkg.sv
// Shared brick definitions: scan FSM state encoding, ball size and the
// brick memory record layout used by both the memory and the scan controller.
package brick_pkg;

  localparam int BALL_SZ = 2;
  localparam int COORD_W = 8;
  localparam int SIZE_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CHECK,
    CLEAR,
    DONE
  } scan_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
    logic               active;
  } brick_t;

endpackage

// File: rtl/brick_scan_controller_if.sv
// Brick memory port: registered-read address/data plus the active-bit clear strobe.
interface brick_scan_controller_if #(
  parameter int IDX_W = 6
);
  import brick_pkg::*;

  logic [IDX_W-1:0]   brick_index;
  logic               writeEnable;
  logic [COORD_W-1:0] brickX;
  logic [COORD_W-1:0] brickY;
  logic [SIZE_W-1:0]  brickW;
  logic [SIZE_W-1:0]  brickH;
  logic               brickActive;

  modport master (
    output brick_index, writeEnable,
    input  brickX, brickY, brickW, brickH, brickActive
  );

  modport slave (
    input  brick_index, writeEnable,
    output brickX, brickY, brickW, brickH, brickActive
  );

endinterface

// File: rtl/brick_overlap.sv
// Combinational ball/brick rectangle intersection, evaluated at 9 bits so
// right/bottom edges near 255 never wrap.
module brick_overlap #(
  parameter int BALL_SZ = brick_pkg::BALL_SZ
) (
  input  logic [brick_pkg::COORD_W-1:0] ballX,
  input  logic [brick_pkg::COORD_W-1:0] ballY,
  input  logic [brick_pkg::COORD_W-1:0] brickX,
  input  logic [brick_pkg::COORD_W-1:0] brickY,
  input  logic [brick_pkg::SIZE_W-1:0]  brickW,
  input  logic [brick_pkg::SIZE_W-1:0]  brickH,
  output logic                          overlap
);

  localparam logic [8:0] BALL_EXT = 9'(BALL_SZ);

  logic [8:0] brick_right;
  logic [8:0] brick_bottom;
  logic [8:0] ball_right;
  logic [8:0] ball_bottom;

  assign brick_right  = {1'b0, brickX} + {5'b0, brickW};
  assign brick_bottom = {1'b0, brickY} + {5'b0, brickH};
  assign ball_right   = {1'b0, ballX} + BALL_EXT;
  assign ball_bottom  = {1'b0, ballY} + BALL_EXT;

  // A zero-sized brick would otherwise still match a ball one pixel to its left or top.
  assign overlap = (brickW != '0) && (brickH != '0) &&
                   ({1'b0, ballX}  < brick_right) &&
                   ({1'b0, brickX} < ball_right)  &&
                   ({1'b0, ballY}  < brick_bottom) &&
                   ({1'b0, brickY} < ball_bottom);

endmodule

// File: rtl/brick_scan_controller.sv
// Walks the brick memory once per start request, clears the lowest-index
// active brick the ball overlaps, and reports the remaining active count.
module brick_scan_controller #(
  parameter int N_BRICKS = 40,
  parameter int IDX_W    = 6,
  parameter int BALL_SZ  = brick_pkg::BALL_SZ
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [brick_pkg::COORD_W-1:0] ballX,
  input  logic [brick_pkg::COORD_W-1:0] ballY,
  brick_scan_controller_if.master       mem,
  output logic                          busy,
  output logic                          done,
  output logic                          hit,
  output logic [IDX_W-1:0]              hitIndex,
  output logic [IDX_W:0]                bricksLeft,
  output logic                          allClear
);
  import brick_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_BRICKS - 1);
  localparam logic [IDX_W:0]   RESET_COUNT = (IDX_W + 1)'(N_BRICKS);

  scan_state_t        state;
  scan_state_t        next_state;
  logic [IDX_W-1:0]   scan_idx;
  logic [COORD_W-1:0] ball_x_q;
  logic [COORD_W-1:0] ball_y_q;
  logic [IDX_W:0]     active_cnt;
  logic               overlap;
  logic               is_last;
  logic               take_clear;

  brick_overlap #(
    .BALL_SZ (BALL_SZ)
  ) u_overlap (
    .ballX   (ball_x_q),
    .ballY   (ball_y_q),
    .brickX  (mem.brickX),
    .brickY  (mem.brickY),
    .brickW  (mem.brickW),
    .brickH  (mem.brickH),
    .overlap (overlap)
  );

  assign is_last    = (scan_idx == LAST_IDX);
  assign take_clear = mem.brickActive && overlap && !hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ADDR;
      ADDR:    next_state = CHECK;
      CHECK: begin
        if (take_clear)   next_state = CLEAR;
        else if (is_last) next_state = DONE;
        else              next_state = ADDR;
      end
      CLEAR:   next_state = is_last ? DONE : ADDR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The clear strobe is decoded from state so a reset drops it without waiting for a clock.
  always_comb begin
    mem.brick_index = scan_idx;
    mem.writeEnable = (state == CLEAR);
    busy            = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx   <= '0;
      ball_x_q   <= '0;
      ball_y_q   <= '0;
      active_cnt <= '0;
      hit        <= 1'b0;
      hitIndex   <= '0;
      done       <= 1'b0;
      bricksLeft <= RESET_COUNT;
      allClear   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ball_x_q   <= ballX;
            ball_y_q   <= ballY;
            scan_idx   <= '0;
            hit        <= 1'b0;
            active_cnt <= '0;
          end
        end
        CHECK: begin
          // The brick being cleared is deliberately left out of the active count.
          if (!take_clear) begin
            if (mem.brickActive) active_cnt <= active_cnt + 1'b1;
            if (!is_last)        scan_idx   <= scan_idx + 1'b1;
          end
        end
        CLEAR: begin
          hit      <= 1'b1;
          hitIndex <= scan_idx;
          if (!is_last) scan_idx <= scan_idx + 1'b1;
        end
        DONE: begin
          done       <= 1'b1;
          bricksLeft <= active_cnt;
          allClear   <= (active_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_scan_controller.sv
// Self-checking bench for brick_scan_controller: directed vector table, corner
// sequences and randomized scans against a loop-based reference model.
module tb_brick_scan_controller;
  import brick_pkg::*;

  localparam int N     = 40;
  localparam int IW    = 6;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [7:0] ball_x;
    logic [7:0] ball_y;
    logic [7:0] brick_x;
    logic [7:0] brick_y;
    logic [3:0] brick_w;
    logic [3:0] brick_h;
    logic       exp_hit;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    ballX;
  logic [7:0]    ballY;
  logic          busy;
  logic          done;
  logic          hit;
  logic [IW-1:0] hitIndex;
  logic [IW:0]   bricksLeft;
  logic          allClear;
  logic          load_mem;

  brick_t mem   [DEPTH];
  brick_t stage [DEPTH];
  brick_t rd;
  vec_t   vecs  [12];

  int checks = 0;
  int errors = 0;

  brick_scan_controller_if #(.IDX_W(IW)) bus ();

  brick_scan_controller #(
    .N_BRICKS (N),
    .IDX_W    (IW),
    .BALL_SZ  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ballX      (ballX),
    .ballY      (ballY),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .hitIndex   (hitIndex),
    .bricksLeft (bricksLeft),
    .allClear   (allClear)
  );

  always #5 clk = ~clk;

  // Brick memory: registered read, active-bit clear on writeEnable, bulk load from stage.
  always @(posedge clk) begin
    if (load_mem) mem <= stage;
    else if (bus.writeEnable) mem[bus.brick_index].active <= 1'b0;
    rd <= mem[bus.brick_index];
  end

  assign bus.brickX      = rd.x;
  assign bus.brickY      = rd.y;
  assign bus.brickW      = rd.w;
  assign bus.brickH      = rd.h;
  assign bus.brickActive = rd.active;

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit touches(input brick_t b, input int bx, input int by);
    int x = int'(b.x);
    int y = int'(b.y);
    int w = int'(b.w);
    int h = int'(b.h);
    return (w > 0) && (h > 0) && (bx < x + w) && (x < bx + BALL_SZ) &&
           (by < y + h) && (y < by + BALL_SZ);
  endfunction

  // Reference: first active touching brick is cleared, every other active brick is counted.
  function automatic void model_scan(input logic [7:0] bx, input logic [7:0] by,
                                     output int hidx, output int left);
    hidx = -1;
    left = 0;
    for (int i = 0; i < N; i++) begin
      if (stage[i].active) begin
        if (hidx < 0 && touches(stage[i], int'(bx), int'(by))) hidx = i;
        else left++;
      end
    end
  endfunction

  task automatic load_bricks();
    @(negedge clk);
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
  endtask

  task automatic clear_stage();
    for (int i = 0; i < DEPTH; i++) stage[i] = '0;
  endtask

  task automatic apply_stimulus(input logic [7:0] bx, input logic [7:0] by,
                                output int lat, output int we_cnt, output int we_idx);
    bit got = 1'b0;
    @(negedge clk);
    ballX  = bx;
    ballY  = by;
    start  = 1'b1;
    lat    = -1;
    we_cnt = 0;
    we_idx = -1;
    for (int c = 1; c <= 200 && !got; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.writeEnable) begin
        we_cnt++;
        we_idx = int'(bus.brick_index);
      end
      if (done) begin
        got = 1'b1;
        lat = c;
      end
    end
  endtask

  task automatic check_output(input string tag, input int exp_idx, input int exp_left,
                              input int lat, input int we_cnt, input int we_idx);
    longint act_bits = 0;
    longint exp_bits = 0;
    bit exp_hit = (exp_idx >= 0);
    check_val($sformatf("%s.latency", tag), lat, exp_hit ? 2*N+3 : 2*N+2);
    check_val($sformatf("%s.hit", tag), hit, exp_hit);
    check_val($sformatf("%s.writes", tag), we_cnt, exp_hit ? 1 : 0);
    if (exp_hit) begin
      check_val($sformatf("%s.hitIndex", tag), hitIndex, exp_idx);
      check_val($sformatf("%s.writeIndex", tag), we_idx, exp_idx);
      stage[exp_idx].active = 1'b0;
    end
    check_val($sformatf("%s.bricksLeft", tag), bricksLeft, exp_left);
    check_val($sformatf("%s.allClear", tag), allClear, exp_left == 0);
    check_val($sformatf("%s.busy", tag), busy, 0);
    for (int i = 0; i < N; i++) begin
      act_bits[i] = mem[i].active;
      exp_bits[i] = stage[i].active;
    end
    check_val($sformatf("%s.memActive", tag), act_bits, exp_bits);
  endtask

  task automatic run_model_scan(input string tag, input logic [7:0] bx, input logic [7:0] by);
    int hidx, left, lat, wc, wi;
    model_scan(bx, by, hidx, left);
    apply_stimulus(bx, by, lat, wc, wi);
    check_output(tag, hidx, left, lat, wc, wi);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, wc, wi;
    int n_done, first_lat, second_lat, first_idx, first_left, second_left;
    bit first_hit, second_hit, seen_clear;
    int done_after_reset;

    reset    = 1'b0;
    start    = 1'b0;
    ballX    = '0;
    ballY    = '0;
    load_mem = 1'b0;
    clear_stage();

    vecs[0]  = '{8'd26,  8'd22,  8'd20,  8'd20,  4'd8,  4'd4,  1'b1};
    vecs[1]  = '{8'd28,  8'd20,  8'd20,  8'd20,  4'd8,  4'd4,  1'b0};
    vecs[2]  = '{8'd27,  8'd20,  8'd20,  8'd20,  4'd8,  4'd4,  1'b1};
    vecs[3]  = '{8'd18,  8'd20,  8'd20,  8'd20,  4'd8,  4'd4,  1'b0};
    vecs[4]  = '{8'd19,  8'd20,  8'd20,  8'd20,  4'd8,  4'd4,  1'b1};
    vecs[5]  = '{8'd20,  8'd24,  8'd20,  8'd20,  4'd8,  4'd4,  1'b0};
    vecs[6]  = '{8'd20,  8'd18,  8'd20,  8'd20,  4'd8,  4'd4,  1'b0};
    vecs[7]  = '{8'd20,  8'd19,  8'd20,  8'd20,  4'd8,  4'd4,  1'b1};
    vecs[8]  = '{8'd19,  8'd20,  8'd20,  8'd20,  4'd0,  4'd4,  1'b0};
    vecs[9]  = '{8'd20,  8'd19,  8'd20,  8'd20,  4'd8,  4'd0,  1'b0};
    vecs[10] = '{8'd254, 8'd254, 8'd250, 8'd250, 4'd15, 4'd15, 1'b1};
    vecs[11] = '{8'd255, 8'd0,   8'd0,   8'd0,   4'd15, 4'd15, 1'b0};

    repeat (2) @(negedge clk);
    check_val("reset.brick_index", bus.brick_index, 0);
    check_val("reset.writeEnable", bus.writeEnable, 0);
    check_val("reset.busy", busy, 0);
    check_val("reset.done", done, 0);
    check_val("reset.hit", hit, 0);
    check_val("reset.hitIndex", hitIndex, 0);
    check_val("reset.bricksLeft", bricksLeft, N);
    check_val("reset.allClear", allClear, 0);
    reset = 1'b1;

    $display("[TB] all bricks inactive");
    clear_stage();
    load_bricks();
    apply_stimulus(8'd10, 8'd10, lat, wc, wi);
    check_output("empty", -1, 0, lat, wc, wi);

    $display("[TB] vector table, single brick at index 5");
    for (int k = 0; k < 12; k++) begin
      clear_stage();
      stage[5] = '{vecs[k].brick_x, vecs[k].brick_y, vecs[k].brick_w, vecs[k].brick_h, 1'b1};
      load_bricks();
      apply_stimulus(vecs[k].ball_x, vecs[k].ball_y, lat, wc, wi);
      check_output($sformatf("vec%0d", k), vecs[k].exp_hit ? 5 : -1,
                   vecs[k].exp_hit ? 0 : 1, lat, wc, wi);
    end

    $display("[TB] two overlapping bricks, lowest index wins");
    clear_stage();
    stage[3]  = '{8'd20,  8'd20,  4'd8, 4'd4, 1'b1};
    stage[7]  = '{8'd22,  8'd20,  4'd8, 4'd4, 1'b1};
    stage[10] = '{8'd100, 8'd100, 4'd4, 4'd4, 1'b1};
    load_bricks();
    apply_stimulus(8'd26, 8'd22, lat, wc, wi);
    check_output("lowest", 3, 2, lat, wc, wi);

    $display("[TB] randomized scans");
    for (int s = 0; s < 24; s++) begin
      if (s % 4 == 0) begin
        clear_stage();
        for (int i = 0; i < N; i++) begin
          stage[i].x      = 8'($urandom_range(0, 47));
          stage[i].y      = 8'($urandom_range(0, 47));
          stage[i].w      = 4'($urandom_range(0, 15));
          stage[i].h      = 4'($urandom_range(0, 15));
          stage[i].active = 1'($urandom_range(0, 1));
        end
        load_bricks();
      end
      run_model_scan($sformatf("rand%0d", s), 8'($urandom_range(0, 50)), 8'($urandom_range(0, 50)));
    end

    $display("[TB] reset during CLEAR");
    clear_stage();
    stage[2] = '{8'd100, 8'd100, 4'd4, 4'd4, 1'b1};
    stage[5] = '{8'd20,  8'd20,  4'd8, 4'd4, 1'b1};
    load_bricks();
    @(negedge clk);
    ballX = 8'd26;
    ballY = 8'd22;
    start = 1'b1;
    seen_clear = 1'b0;
    for (int c = 0; c < 200 && !seen_clear; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.writeEnable) seen_clear = 1'b1;
    end
    check_val("rstClear.reachedClear", seen_clear, 1);
    reset = 1'b0;
    #1;
    check_val("rstClear.writeEnable", bus.writeEnable, 0);
    check_val("rstClear.busy", busy, 0);
    check_val("rstClear.done", done, 0);
    check_val("rstClear.hit", hit, 0);
    check_val("rstClear.hitIndex", hitIndex, 0);
    check_val("rstClear.bricksLeft", bricksLeft, N);
    check_val("rstClear.allClear", allClear, 0);
    check_val("rstClear.brick_index", bus.brick_index, 0);
    repeat (2) @(negedge clk);
    check_val("rstClear.memKept", mem[5].active, 1);
    reset = 1'b1;
    done_after_reset = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done) done_after_reset++;
    end
    check_val("rstClear.noDone", done_after_reset, 0);

    $display("[TB] start held high, ball moved mid-scan");
    load_bricks();
    @(negedge clk);
    ballX = 8'd26;
    ballY = 8'd22;
    start = 1'b1;
    n_done = 0;
    first_lat = -1; second_lat = -1; first_idx = -1; first_left = -1; second_left = -1;
    first_hit = 1'b0; second_hit = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 3) ballX = 8'd100;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_lat  = c;
          first_hit  = hit;
          first_idx  = int'(hitIndex);
          first_left = int'(bricksLeft);
        end else if (n_done == 2) begin
          second_lat  = c;
          second_hit  = hit;
          second_left = int'(bricksLeft);
        end
      end
    end
    start = 1'b0;
    for (int c = 0; c < 300 && busy; c++) @(negedge clk);
    check_val("held.doneCount", n_done, 2);
    check_val("held.firstLatency", first_lat, 2*N+3);
    check_val("held.firstHit", first_hit, 1);
    check_val("held.firstHitIndex", first_idx, 5);
    check_val("held.firstLeft", first_left, 1);
    check_val("held.secondLatency", second_lat, 2*N+3 + 2*N+2);
    check_val("held.secondHit", second_hit, 0);
    check_val("held.secondLeft", second_left, 1);
    check_val("held.memCleared", mem[5].active, 0);
    check_val("held.idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
